// File: rtl/pwm_pkg.sv
// Shared types for the PWM dead-time stage: FSM state encoding and default counter width.
// Pure declarations, no logic.
package pwm_pkg;

   localparam int DT_WIDTH_DEFAULT = 4;

   typedef enum logic [2:0] {
      OFF   = 3'd0,
      DT_HS = 3'd1,
      HS_ON = 3'd2,
      DT_LS = 3'd3,
      LS_ON = 3'd4,
      FAULT = 3'd5
   } dt_state_t;

endpackage

// File: rtl/pwm_deadtime_cnt.sv
// Loadable down-counter that times the both-off interval and saturates at zero.
// Load takes effect on the next edge; zero flag is combinational from the count.
module pwm_deadtime_cnt #(
   parameter int DT_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [DT_WIDTH-1:0] load_val,
   input  logic                dec,
   output logic                zero
);

   localparam logic [DT_WIDTH-1:0] ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

   logic [DT_WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - ONE;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Turns a single-ended PWM into a complementary gate-drive pair with a guaranteed both-off gap
// of dead_time+1 cycles; outputs are registered, 1-cycle latency from any sampled input.
module pwm_deadtime
   import pwm_pkg::*;
#(
   parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                pwm_in,
   input  logic [DT_WIDTH-1:0] dead_time,
   input  logic                fault_in,
   input  logic                fault_clr,
   output logic                hs_out,
   output logic                ls_out,
   output logic                in_deadtime,
   output logic                fault_latched
);

   dt_state_t state;
   dt_state_t nxt;
   logic      cnt_load;
   logic      cnt_dec;
   logic      cnt_zero;

   pwm_deadtime_cnt #(
      .DT_WIDTH (DT_WIDTH)
   ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (dead_time),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Any change of direction, including one mid-interval, restarts the full dead time.
   always_comb begin
      nxt      = state;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      if (fault_in) begin
         nxt = FAULT;
      end else if ((state != FAULT) && !ena) begin
         nxt = OFF;
      end else begin
         case (state)
            OFF: begin
               nxt      = pwm_in ? DT_HS : DT_LS;
               cnt_load = 1'b1;
            end
            HS_ON: begin
               if (!pwm_in) begin
                  nxt      = DT_LS;
                  cnt_load = 1'b1;
               end
            end
            LS_ON: begin
               if (pwm_in) begin
                  nxt      = DT_HS;
                  cnt_load = 1'b1;
               end
            end
            DT_HS: begin
               if (!pwm_in) begin
                  nxt      = DT_LS;
                  cnt_load = 1'b1;
               end else if (cnt_zero) begin
                  nxt = HS_ON;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            DT_LS: begin
               if (pwm_in) begin
                  nxt      = DT_HS;
                  cnt_load = 1'b1;
               end else if (cnt_zero) begin
                  nxt = LS_ON;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            FAULT: begin
               if (fault_clr) begin
                  nxt = OFF;
               end
            end
            default: begin
               nxt = OFF;
            end
         endcase
      end
   end

   // Outputs are registered copies of the next-state decode so they stay glitch-free
   // and drop asynchronously with reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= OFF;
         hs_out        <= 1'b0;
         ls_out        <= 1'b0;
         in_deadtime   <= 1'b0;
         fault_latched <= 1'b0;
      end else begin
         state         <= nxt;
         hs_out        <= (nxt == HS_ON);
         ls_out        <= (nxt == LS_ON);
         in_deadtime   <= (nxt == DT_HS) || (nxt == DT_LS);
         fault_latched <= (nxt == FAULT);
      end
   end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: a timing-rule reference model queues expected outputs per edge,
// a monitor pops and compares them one step after each rising edge.
module tb_pwm_deadtime;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       pwm_in = 1'b0;
   logic [3:0] dead_time = 4'd0;
   logic       fault_in = 1'b0;
   logic       fault_clr = 1'b0;
   logic       hs_out;
   logic       ls_out;
   logic       in_deadtime;
   logic       fault_latched;

   int n_checks = 0;
   int n_pass = 0;

   logic [3:0] exp_q[$];

   // Model: the drive on the committed side comes on once more than the committed dead time
   // has elapsed since the commit; a commit happens on engage or any pwm level change.
   bit m_fault = 1'b0;
   bit m_eng = 1'b0;
   bit m_lvl = 1'b0;
   int m_since = 0;
   int m_dtc = 0;

   always #5 clk = ~clk;

   pwm_deadtime dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .pwm_in        (pwm_in),
      .dead_time     (dead_time),
      .fault_in      (fault_in),
      .fault_clr     (fault_clr),
      .hs_out        (hs_out),
      .ls_out        (ls_out),
      .in_deadtime   (in_deadtime),
      .fault_latched (fault_latched)
   );

   function automatic logic [3:0] model_out();
      logic drv;
      drv = m_eng && (m_since > m_dtc);
      return {drv && m_lvl, drv && !m_lvl, m_eng && (m_since <= m_dtc), m_fault};
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %b required %b (hs,ls,dt,flt)", name, $time, act, exp);
   endtask

   task automatic step(input bit rn, input bit en, input bit p, input logic [3:0] dt,
                       input bit fi, input bit fc);
      @(negedge clk);
      rst_n = rn; ena = en; pwm_in = p; dead_time = dt; fault_in = fi; fault_clr = fc;
      if (!rn) begin
         m_fault = 1'b0; m_eng = 1'b0; m_since = 0; m_dtc = 0;
      end else if (fi) begin
         m_fault = 1'b1; m_eng = 1'b0;
      end else if (m_fault) begin
         if (fc) m_fault = 1'b0;
      end else if (!en) begin
         m_eng = 1'b0;
      end else if (!m_eng || (p != m_lvl)) begin
         m_eng = 1'b1; m_lvl = p; m_since = 0; m_dtc = int'(dt);
      end else if (m_since < 1000) begin
         m_since++;
      end
      exp_q.push_back(model_out());
   endtask

   task automatic run(input int n, input bit p, input logic [3:0] dt);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, p, dt, 1'b0, 1'b0);
   endtask

   // Monitor
   initial begin
      logic [3:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", {hs_out, ls_out, in_deadtime, fault_latched}, e);
            check("exclusive", {3'b000, hs_out & ls_out}, 4'b0000);
         end
      end
   end

   initial begin
      bit p;
      logic [3:0] dt;
      // reset hold and release
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
      // complementary drive, dead_time 3, toggle every 20
      for (int k = 0; k < 4; k++) run(20, k[0] ? 1'b0 : 1'b1, 4'd3);
      // minimum dead time, toggle every 5
      for (int k = 0; k < 6; k++) run(5, k[0] ? 1'b0 : 1'b1, 4'd0);
      // glitch during HS_ON with dead_time 7
      run(20, 1'b1, 4'd7);
      run(2, 1'b0, 4'd7);
      run(20, 1'b1, 4'd7);
      // fault from LS_ON, clear while held, then real clear
      run(15, 1'b0, 4'd2);
      step(1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1);
      run(10, 1'b1, 4'd2);
      // disable in HS_ON and re-enable
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
      run(10, 1'b1, 4'd4);
      // dead_time changed mid-interval
      run(10, 1'b1, 4'd2);
      run(1, 1'b0, 4'd2);
      run(10, 1'b0, 4'd9);
      // asynchronous reset while in HS_ON
      run(15, 1'b1, 4'd3);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", {hs_out, ls_out, in_deadtime, fault_latched}, 4'b0000);
      m_fault = 1'b0; m_eng = 1'b0; m_since = 0; m_dtc = 0;
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
      run(10, 1'b1, 4'd3);
      // randomized operation
      p = 1'b0;
      dt = 4'd3;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(5) == 0) p = ~p;
         if ($urandom_range(19) == 0) dt = 4'($urandom_range(15));
         step(1'b1, $urandom_range(39) != 0, p, dt,
              $urandom_range(99) == 0, $urandom_range(7) == 0);
      end
      repeat (3) @(posedge clk);
      #2;
      check("drain", 4'(exp_q.size()), 4'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
